ball_engine: RTL

//  Game-logic stage feeding the per-player VGA render wrappers.
//  - Owns ball position, direction, speed and both scores.
//  - Advances once per video frame: wall bounces, paddle collision, point scoring, serve/game-over sequencing.
//  - Inputs: paddle Y positions from the two player nodes.
//  - Outputs: registered ball X/Y (11-bit pixel coordinates) broadcast to both render wrappers.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/paddle_hit.sv | 17 +
 rtl/ball_engine.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared Pong types and geometry for the game-logic stage and the render wrappers.
package pong_pkg;

  typedef logic [10:0]        coord_t;
  typedef logic signed [11:0] step_t;

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORED, OVER} ball_state_e;

  localparam int unsigned SCREEN_W    = 800;
  localparam int unsigned SCREEN_H    = 600;
  localparam int unsigned BALL_SIZE   = 8;
  localparam int unsigned PADDLE_W    = 8;
  localparam int unsigned PADDLE_H    = 80;
  localparam int unsigned P1_X        = 40;
  localparam int unsigned P2_X        = 752;
  localparam int unsigned SPEED       = 4;
  localparam int unsigned MAX_SPEED   = 8;
  localparam int unsigned SERVE_DELAY = 60;
  localparam int unsigned WIN_SCORE   = 7;

  localparam coord_t CENTRE_X = coord_t'((SCREEN_W - BALL_SIZE) / 2);
  localparam coord_t CENTRE_Y = coord_t'((SCREEN_H - BALL_SIZE) / 2);

  localparam step_t ZERO_S = '0;
  localparam step_t X_MAX  = step_t'(SCREEN_W - BALL_SIZE);
  localparam step_t Y_MAX  = step_t'(SCREEN_H - BALL_SIZE);
  localparam step_t L_FACE = step_t'(P1_X + PADDLE_W);
  localparam step_t R_FACE = step_t'(P2_X - BALL_SIZE);

endpackage

// File: rtl/paddle_hit.sv
// Vertical overlap test between the ball square and one paddle.
module paddle_hit
  import pong_pkg::*;
(
  input  logic [10:0] ball_y_i,
  input  logic [10:0] paddle_y_i,
  output logic        hit_o
);

  // One extra bit so paddle_y + PADDLE_H cannot wrap.
  logic [11:0] by, py;

  assign by    = {1'b0, ball_y_i};
  assign py    = {1'b0, paddle_y_i};
  assign hit_o = ((by + 12'(BALL_SIZE)) > py) && (by < (py + 12'(PADDLE_H)));

endmodule

// File: rtl/ball_engine.sv
// Pong ball/score engine, advanced once per frame. Define BALL_SPEEDUP_EN to
// make each paddle hit raise the ball speed up to MAX_SPEED.
module ball_engine
  import pong_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        point,
  output logic        game_over
);

  localparam logic [3:0] SPEED_INIT = 4'(SPEED);
  localparam logic [5:0] SERVE_INIT = 6'(SERVE_DELAY);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  ball_state_e state_q;
  coord_t      x_q, y_q;
  logic        dir_x_q, dir_y_q;
  logic [3:0]  speed_q, score_p1_q, score_p2_q;
  logic [5:0]  timer_q;
  logic        point_q, game_over_q;

  step_t      x_s, y_s, spd, nx, ny, y_c_d;
  logic       dir_y_d, ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;
  logic [3:0] speed_hit_d;

  always_comb begin
    x_s     = {1'b0, x_q};
    y_s     = {1'b0, y_q};
    spd     = {8'b0, speed_q};
    nx      = dir_x_q ? x_s + spd : x_s - spd;
    ny      = dir_y_q ? y_s + spd : y_s - spd;
    y_c_d   = ny;
    dir_y_d = dir_y_q;
    if (ny <= ZERO_S) begin
      y_c_d   = ZERO_S;
      dir_y_d = 1'b1;
    end else if (ny >= Y_MAX) begin
      y_c_d   = Y_MAX;
      dir_y_d = 1'b0;
    end
  end

  paddle_hit u_hit_p1 (.ball_y_i(y_c_d[10:0]), .paddle_y_i(p1_y), .hit_o(ov_l));
  paddle_hit u_hit_p2 (.ball_y_i(y_c_d[10:0]), .paddle_y_i(p2_y), .hit_o(ov_r));

  // The face-side position checks stop a ball already behind a paddle from being returned.
  assign hit_l  = !dir_x_q && (x_s >= L_FACE) && (nx <= L_FACE) && ov_l;
  assign hit_r  =  dir_x_q && (x_s <= R_FACE) && (nx >= R_FACE) && ov_r;
  assign miss_l = nx <= ZERO_S;
  assign miss_r = nx >= X_MAX;

`ifdef BALL_SPEEDUP_EN
  assign speed_hit_d = (speed_q >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : speed_q + 4'd1;
`else
  assign speed_hit_d = SPEED_INIT;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= CENTRE_X;
      y_q         <= CENTRE_Y;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      speed_q     <= SPEED_INIT;
      timer_q     <= '0;
      score_p1_q  <= '0;
      score_p2_q  <= '0;
      point_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      point_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= SERVE;
          timer_q <= SERVE_INIT;
        end
        SERVE: if (frame_tick) begin
          if (timer_q == 6'd1) state_q <= PLAY;
          else                 timer_q <= timer_q - 6'd1;
        end
        PLAY: if (frame_tick) begin
          y_q     <= y_c_d[10:0];
          dir_y_q <= dir_y_d;
          if (hit_l) begin
            x_q     <= L_FACE[10:0];
            dir_x_q <= 1'b1;
            speed_q <= speed_hit_d;
          end else if (hit_r) begin
            x_q     <= R_FACE[10:0];
            dir_x_q <= 1'b0;
            speed_q <= speed_hit_d;
          end else if (miss_l || miss_r) begin
            // Scoring is committed here so point is high exactly during SCORED.
            state_q <= SCORED;
            point_q <= 1'b1;
            x_q     <= CENTRE_X;
            y_q     <= CENTRE_Y;
            speed_q <= SPEED_INIT;
            dir_x_q <= miss_r;
            if (miss_l) score_p2_q <= score_p2_q + 4'd1;
            else        score_p1_q <= score_p1_q + 4'd1;
          end else begin
            x_q <= nx[10:0];
          end
        end
        SCORED: begin
          if (score_p1_q == WIN || score_p2_q == WIN) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
          end else begin
            state_q <= SERVE;
            timer_q <= SERVE_INIT;
          end
        end
        OVER: if (start) begin
          state_q     <= SERVE;
          timer_q     <= SERVE_INIT;
          score_p1_q  <= '0;
          score_p2_q  <= '0;
          game_over_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign score_p1  = score_p1_q;
  assign score_p2  = score_p2_q;
  assign point     = point_q;
  assign game_over = game_over_q;

endmodule
